// File: rtl/riscv_next_pkg.sv
// Shared jump-predictor types: return-address-stack depth and checkpoint layout.
package riscv_next_pkg;

  localparam int RAS_INDEX_WIDTH = 3;
  localparam int RAS_DEPTH       = 2 ** RAS_INDEX_WIDTH;

  // Pointer state the backend snapshots and later hands back on a misprediction.
  typedef struct packed {
    logic [RAS_INDEX_WIDTH-1:0] ptr;
    logic [RAS_INDEX_WIDTH:0]   count;
  } ras_ckpt_t;

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address stack feeding the jump predictor. Fetch pushes link addresses
// on predicted calls and pops on return-table hits; the popped address is the
// registered predicted return target one cycle later. The build only pulls this
// file in when USE_JUMP_PREDICTOR is defined.
module ret_addr_stack
  import riscv_next_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int INDEX_WIDTH = RAS_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   i_stall,
  input  logic                   i_push,
  input  logic [ADDR_WIDTH-1:0]  i_push_addr,
  input  logic                   i_pop,
  output logic [ADDR_WIDTH-1:0]  o_pred_addr,
  output logic                   o_pred_valid,
  output logic [INDEX_WIDTH-1:0] o_ckpt_ptr,
  output logic [INDEX_WIDTH:0]   o_ckpt_count,
  input  logic                   i_recover,
  input  logic [INDEX_WIDTH-1:0] i_recover_ptr,
  input  logic [INDEX_WIDTH:0]   i_recover_count
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;
  localparam logic [INDEX_WIDTH:0] DEPTH_C = (INDEX_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0]  entries [DEPTH];
  logic [INDEX_WIDTH-1:0] ptr, ptr_n;
  logic [INDEX_WIDTH:0]   count, count_n;
  logic [ADDR_WIDTH-1:0]  pred_addr_n;
  logic                   pred_valid_n;
  logic                   wr_en;
  logic [INDEX_WIDTH-1:0] wr_idx;
  logic                   overflow_evt, underflow_evt;

  assign o_ckpt_ptr   = ptr;
  assign o_ckpt_count = count;

  // Decode the single action taken this cycle (recover > pop > swap > push > idle).
  always_comb begin
    ptr_n         = ptr;
    count_n       = count;
    pred_addr_n   = o_pred_addr;
    pred_valid_n  = o_pred_valid;
    wr_en         = 1'b0;
    wr_idx        = ptr;
    overflow_evt  = 1'b0;
    underflow_evt = 1'b0;
    if (!reset && enable && !i_stall) begin
      pred_valid_n = 1'b0;
      if (i_recover) begin
        ptr_n   = i_recover_ptr;
        count_n = (i_recover_count > DEPTH_C) ? DEPTH_C : i_recover_count;
      end else if (i_pop && !i_push) begin
        if (count != '0) begin
          pred_addr_n  = entries[ptr];
          pred_valid_n = 1'b1;
          ptr_n        = ptr - 1'b1;
          count_n      = count - 1'b1;
        end else begin
          underflow_evt = 1'b1;
        end
      end else if (i_push && i_pop && count != '0) begin
        pred_addr_n  = entries[ptr];
        pred_valid_n = 1'b1;
        wr_en        = 1'b1;
        wr_idx       = ptr;
      end else if (i_push) begin
        wr_en        = 1'b1;
        wr_idx       = ptr + 1'b1;
        ptr_n        = ptr + 1'b1;
        overflow_evt = (count == DEPTH_C);
        count_n      = (count == DEPTH_C) ? count : count + 1'b1;
      end
    end
  end

  // Pointer, occupancy and prediction registers; reset discards everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr          <= '0;
      count        <= '0;
      o_pred_addr  <= '0;
      o_pred_valid <= 1'b0;
    end else begin
      ptr          <= ptr_n;
      count        <= count_n;
      o_pred_addr  <= pred_addr_n;
      o_pred_valid <= pred_valid_n;
    end
  end

  // Stack storage is never cleared; stale slots are unreachable once count drops.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entries[wr_idx] <= i_push_addr;
    end
  end

`ifndef SYNTHESIS
  int unsigned overflow_count;
  int unsigned underflow_count;

  // Debug tallies of wrap-around pushes and empty-stack pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_count  <= 0;
      underflow_count <= 0;
    end else begin
      if (overflow_evt)  overflow_count  <= overflow_count + 1;
      if (underflow_evt) underflow_count <= underflow_count + 1;
    end
  end
`endif

endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- Return-address stack (RAS) for the jump predictor, directly downstream of the return-instruction table.
- Fetch pushes the link address on every predicted call.
- When the return table flags the current fetch address as a return (its registered valid output), fetch pops this stack. The popped address becomes the predicted return target on the following cycle.
- Checkpoint outputs and a recover input let the backend restore pointer state after a misprediction.
- The block is compiled only when USE_JUMP_PREDICTOR is defined.

Parameters:
ADDR_WIDTH, 64, width of stored return addresses
INDEX_WIDTH, 3, log2 of stack depth; DEPTH = 2**INDEX_WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous reset, active-high
enable  input  1  predictor enable; when low, all state holds
i_stall  input  1  pipeline stall; when high, all state holds
i_push  input  1  push request (predicted call)
i_push_addr  input  ADDR_WIDTH  return address to push (call PC + 4, computed upstream)
i_pop  input  1  pop request (return-table hit)
o_pred_addr  output  ADDR_WIDTH  predicted return target, registered
o_pred_valid  output  1  o_pred_addr is valid this cycle
o_ckpt_ptr  output  INDEX_WIDTH  current top-of-stack pointer, for checkpointing
o_ckpt_count  output  INDEX_WIDTH+1  current occupancy 0..DEPTH
i_recover  input  1  restore pointer state from checkpoint
i_recover_ptr  input  INDEX_WIDTH  checkpointed pointer
i_recover_count  input  INDEX_WIDTH+1  checkpointed occupancy

Behaviour:
- State:
  - entries[0..DEPTH-1] of ADDR_WIDTH; entries are not reset.
  - ptr: index of the top entry.
  - count: occupancy, saturating at DEPTH.
- Reset (reset=1 at a clock edge): ptr=0, count=0, o_pred_valid=0, o_pred_addr=0.
  - Reset has priority over enable, stall, and all requests.
  - Reset in the middle of a push/pop sequence discards all state.
- Hold condition: enable=0 or i_stall=1. ptr, count, entries, o_pred_addr and o_pred_valid all hold, including a pending o_pred_valid=1.
- Otherwise, exactly one of the following applies per cycle, in priority order:
  - i_recover=1:
    - ptr<=i_recover_ptr; count<=min(i_recover_count, DEPTH); o_pred_valid<=0.
    - i_push and i_pop are ignored; entries are unchanged.
  - i_pop=1 and i_push=0:
    - If count>0: o_pred_addr<=entries[ptr]; o_pred_valid<=1; ptr<=ptr-1 (mod DEPTH); count<=count-1.
    - If count==0 (underflow): o_pred_valid<=0; o_pred_addr holds; ptr and count are unchanged.
  - i_push=1 and i_pop=0:
    - entries[ptr+1]<=i_push_addr; ptr<=ptr+1 (mod DEPTH); count<=min(count+1, DEPTH); o_pred_valid<=0.
    - At count==DEPTH the oldest entry is overwritten (wrap-around overflow).
  - i_push=1 and i_pop=1 (coroutine-style call/return):
    - If count>0: o_pred_addr<=entries[ptr]; o_pred_valid<=1; entries[ptr]<=i_push_addr; ptr and count are unchanged.
    - If count==0: behaves as a push only, with o_pred_valid<=0.
  - Neither request: o_pred_valid<=0.
- Latency:
  - Pop to o_pred_valid/o_pred_addr is 1 cycle.
  - o_pred_valid is a single-cycle pulse per accepted pop, unless a hold condition extends it.
- Checkpoint outputs are combinational copies of ptr and count. They reflect state before this cycle's update.
- Pointer arithmetic is modulo DEPTH. count never exceeds DEPTH and never goes below 0.
- SIMULATION only: integer counters for overflows (push at count==DEPTH) and underflows (pop at count==0).

Decomposition:
- riscv_next_pkg holds:
  - typedef ras_ckpt_t (packed: ptr, count), sized from a package constant RAS_INDEX_WIDTH = 3.
  - localparam RAS_DEPTH.
- No sub-module. Storage plus pointer logic fit in one module of about 150 lines.

Test Plan:
- Reset, then pop with the stack empty -> o_pred_valid=0 the next cycle; o_ckpt_count=0, o_ckpt_ptr=0.
- Push 0x1000, push 0x2000, then pop, pop -> o_pred_addr=0x2000 then 0x1000, each with o_pred_valid=1 one cycle after the pop. Count ends at 0.
- Push 0x100..0x900 (9 pushes, DEPTH=8) -> count=8; 8 pops return 0x900 down to 0x200; 9th pop gives o_pred_valid=0.
- With stack holding 0xA0, 0xB0: push 0xC0 and pop in the same cycle -> o_pred_addr=0xB0, valid=1, count stays 2. The next pop returns 0xC0.
- Save ckpt (ptr=2, count=2), push 0xD0, push 0xE0, assert i_recover with the saved values and i_push=1 simultaneously -> ptr=2, count=2, push ignored. Next pop returns the entry at index 2 (0xB0), not 0xE0.
- Pop with count>0 while i_stall=1 for 3 cycles -> no state change. Pop accepted on the first unstalled cycle. Then assert reset mid-sequence -> o_pred_valid=0, count=0 the next cycle.
